mult_datapath: RTL and testbench
================================

Name: mult_datapath

Overview:
- Arithmetic stage for the sequential 8x8 multiplier. It sits directly downstream of the multiplier control FSM and consumes that FSM's input_sel, shift_sel, clk_ena, sclr_n and done.
- It supplies the 2-bit step count that the FSM uses to sequence itself.
- It forms one 4x4 partial product per enabled cycle, shifts it, and adds it into a 16-bit accumulator. On done it registers the final 16-bit product.

Parameters:
- HOLD_OPERANDS, 1: 1 = latch dataa/datab on the clear cycle and use the latched copies for the whole calculation; 0 = use the live dataa/datab every cycle.
- OVF_STICKY, 1: 1 = overflow stays set until the next clear or reset; 0 = overflow reflects only the most recent accumulate cycle.

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- reset_a  in  1  asynchronous, active-high reset
- dataa  in  8  multiplicand
- datab  in  8  multiplier
- input_sel  in  2  partial-product nibble select from the FSM; may be X when clk_ena=0
- shift_sel  in  2  partial-product shift select from the FSM; may be X when clk_ena=0
- clk_ena  in  1  datapath update enable
- sclr_n  in  1  synchronous clear, active-low; acts only when clk_ena=1
- done  in  1  one-cycle strobe from the FSM: calculation complete
- count  out  2  step counter, fed back to the FSM
- product8x8  out  16  registered final product
- result_valid  out  1  one-cycle pulse when product8x8 updates
- overflow  out  1  accumulator carry-out flag (misuse detector)

Behaviour:
- Interface: one clock, clk. Reset reset_a is asynchronous and active-high. While reset_a=1, every register is 0: count=0, accumulator=0, operand latches=0, product8x8=16'h0000, result_valid=0, overflow=0.
- Register update priority, evaluated each rising clk edge:
  - clk_ena=0: count, accumulator, operand latches and overflow all hold. X on input_sel/shift_sel must never propagate into state.
  - clk_ena=1, sclr_n=0 (clear): count<=0, accumulator<=0, overflow<=0. If HOLD_OPERANDS=1, opA<=dataa and opB<=datab. This restarts cleanly even mid-calculation.
  - clk_ena=1, sclr_n=1 (accumulate): count<=count+1, wrapping 3->0. accumulator<=accumulator+shifted partial product (shifted_pp).
- Partial-product selection:
  - a_nib = input_sel[1] ? A[7:4] : A[3:0]
  - b_nib = input_sel[0] ? B[7:4] : B[3:0]
  - A/B are opA/opB when HOLD_OPERANDS=1, otherwise dataa/datab.
  - pp = a_nib*b_nib, an 8-bit unsigned result.
- Shift by shift_sel: 00 -> pp, 01 -> pp<<4, 10 -> pp<<8, 11 -> pp (unshifted; defined, not X). shifted_pp is zero-extended to 16 bits.
- Sum width and overflow:
  - The sum is computed at 17 bits; the accumulator keeps bits [15:0].
  - Bit 16 set on an accumulate cycle sets overflow.
  - OVF_STICKY=1: overflow holds until the next clear or reset.
  - OVF_STICKY=0: overflow is updated every accumulate cycle and holds when clk_ena=0.
  - A legal four-step sequence never overflows.
- Result register:
  - On a clk edge with done=1: product8x8<=accumulator, and result_valid=1 for exactly the next cycle.
  - done is independent of clk_ena, because the FSM drives clk_ena=0 in its done state.
  - If done=1 coincides with a clear, product8x8 captures the pre-clear accumulator.
  - product8x8 holds its value through new calculations until the next done.
- Timing against the FSM:
  - Start cycle (clear) -> count=0 in the LSB state. Each FSM step sees count 0,1,2,3.
  - The count wraps to 0 on entry to the done state.
  - Latency: final accumulator value is ready 5 edges after start is sampled. product8x8/result_valid appear on the following edge, 6 edges after start.
- Reset asserted mid-operation: all state clears immediately (asynchronously). After reset_a deasserts, the first edge uses the normal priority rules.
- Implementation constraints: no latches, no combinational path from input_sel/shift_sel to any output, count driven from a flop only.

Test Plan:
- Reset: assert reset_a mid-accumulate with accumulator=0x0068 -> count, product8x8, result_valid and overflow are 0 immediately, before any clk edge.
- Legal sequence, dataa=0x12, datab=0x34:
  - Drive clear, then (input_sel, shift_sel) = (00,00), (01,01), (10,01), (11,10), then done.
  - Accumulator steps 0x0008, 0x0068, 0x00A8, 0x03A8; count steps 1, 2, 3, 0.
  - Then product8x8=0x03A8 with a single result_valid pulse.
- Max operands 0xFF x 0xFF via the full FSM handshake -> product8x8=0xFE01, overflow=0.
- Operand hold (HOLD_OPERANDS=1): change dataa/datab to 0x00 after the clear cycle of 0x12 x 0x34 -> result is still 0x03A8.
- Misuse: clear, then two accumulate cycles of (11,10) with 0xFF x 0xFF.
  - Required: accumulator 0xE100, then 0xC200; overflow=1, and with OVF_STICKY=1 it stays 1 until the next clear.
- Gating and restart:
  - clk_ena=0 with input_sel/shift_sel=X for 3 cycles -> no state change and no X on outputs.
  - Then a clear mid-calculation -> count=0, accumulator=0, and the previous product8x8 is retained.

Source files
------------

// File: rtl/mult_datapath_if.sv
// Bus between the multiplier control FSM (master) and the arithmetic datapath (slave).
// Carries operands, step controls, the step count and the result outputs.
interface mult_datapath_if;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [1:0]  input_sel;
  logic [1:0]  shift_sel;
  logic        clk_ena;
  logic        sclr_n;
  logic        done;
  logic [1:0]  count;
  logic [15:0] product8x8;
  logic        result_valid;
  logic        overflow;

  modport master (
    output dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
    input  count, product8x8, result_valid, overflow
  );

  modport slave (
    input  dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
    output count, product8x8, result_valid, overflow
  );
endinterface

// File: rtl/mult_datapath.sv
// Sequential 8x8 multiplier datapath: one shifted 4x4 partial product per enabled
// cycle into a 16-bit accumulator, final product registered on done.
module mult_datapath #(
  parameter bit HOLD_OPERANDS = 1'b1,
  parameter bit OVF_STICKY    = 1'b1
) (
  input  logic            clk,
  input  logic            reset_a,
  mult_datapath_if.slave  bus
);

  logic [7:0]  r_op_a;
  logic [7:0]  r_op_b;
  logic [1:0]  r_count;
  logic [15:0] r_accum;
  logic        r_overflow;
  logic [15:0] r_product;
  logic        r_valid;

  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [7:0]  w_pp;
  logic [15:0] w_shifted_pp;
  logic [16:0] w_sum;

  assign w_a     = HOLD_OPERANDS ? r_op_a : bus.dataa;
  assign w_b     = HOLD_OPERANDS ? r_op_b : bus.datab;
  assign w_a_nib = bus.input_sel[1] ? w_a[7:4] : w_a[3:0];
  assign w_b_nib = bus.input_sel[0] ? w_b[7:4] : w_b[3:0];
  assign w_pp    = {4'b0000, w_a_nib} * {4'b0000, w_b_nib};

  // NOTE: default assigned before the case so every path drives w_shifted_pp (no latch).
  always_comb begin
    w_shifted_pp = {8'h00, w_pp};
    case (bus.shift_sel)
      2'b01:   w_shifted_pp = {4'h0, w_pp, 4'h0};
      2'b10:   w_shifted_pp = {w_pp, 8'h00};
      default: w_shifted_pp = {8'h00, w_pp};
    endcase
  end

  assign w_sum = {1'b0, r_accum} + {1'b0, w_shifted_pp};

  // Selects are only consumed under clk_ena, so X on them never reaches state.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_count    <= '0;
      r_accum    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clk_ena) begin
      if (!bus.sclr_n) begin
        r_count    <= '0;
        r_accum    <= '0;
        r_overflow <= 1'b0;
        if (HOLD_OPERANDS) begin
          r_op_a <= bus.dataa;
          r_op_b <= bus.datab;
        end
      end else begin
        r_count    <= r_count + 2'd1;
        r_accum    <= w_sum[15:0];
        r_overflow <= OVF_STICKY ? (r_overflow | w_sum[16]) : w_sum[16];
      end
    end
  end

  // done is sampled regardless of clk_ena; a coincident clear still sees the old accumulator.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r_product <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= bus.done;
      if (bus.done) r_product <= r_accum;
    end
  end

  assign bus.count        = r_count;
  assign bus.product8x8   = r_product;
  assign bus.result_valid = r_valid;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed FSM-style sequences, a vector
// table of full multiplications, and randomized cycles against an arithmetic model.
module tb_mult_datapath;

  localparam bit HOLD = 1'b1;
  localparam bit STICKY = 1'b1;

  logic clk = 1'b0;
  logic reset_a;
  mult_datapath_if bus ();

  mult_datapath #(.HOLD_OPERANDS(HOLD), .OVF_STICKY(STICKY)) dut (
    .clk(clk), .reset_a(reset_a), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ena, input bit sclr_n, input logic [1:0] isel,
                       input logic [1:0] ssel, input bit done);
    bus.clk_ena   = ena;
    bus.sclr_n    = sclr_n;
    bus.input_sel = isel;
    bus.shift_sel = ssel;
    bus.done      = done;
    tick();
  endtask

  // Legal FSM step order: (input_sel, shift_sel) per step.
  logic [1:0] step_isel [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] step_ssel [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit zero_after,
                          input logic [15:0] exp, input string tag);
    bus.dataa = a;
    bus.datab = b;
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    check({tag, " count after clear"}, 32'(bus.count), 32'd0);
    if (zero_after) begin
      bus.dataa = 8'h00;
      bus.datab = 8'h00;
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, step_isel[k], step_ssel[k], 1'b0);
      check({tag, " count step"}, 32'(bus.count), 32'((k + 1) % 4));
    end
    drive(1'b0, 1'b1, 2'bxx, 2'bxx, 1'b1);
    check({tag, " product"}, 32'(bus.product8x8), 32'(exp));
    check({tag, " valid pulse"}, 32'(bus.result_valid), 32'd1);
    check({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    drive(1'b0, 1'b1, 2'bxx, 2'bxx, 1'b0);
    check({tag, " valid drops"}, 32'(bus.result_valid), 32'd0);
    check({tag, " product holds"}, 32'(bus.product8x8), 32'(exp));
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [6];

  // Reference model state: plain integers, updated from the arithmetic rules.
  int m_opa, m_opb, m_acc, m_cnt, m_prod;
  bit m_ovf, m_valid;

  function automatic int ref_pp(input int a, input int b, input int isel, input int ssel);
    int an, bn, scale;
    an = (isel / 2 == 1) ? (a / 16) : (a % 16);
    bn = (isel % 2 == 1) ? (b / 16) : (b % 16);
    scale = (ssel == 1) ? 16 : (ssel == 2) ? 256 : 1;
    return an * bn * scale;
  endfunction

  initial begin
    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h01, 8'h01, 16'h0001};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    vecs[5] = '{8'hAB, 8'hCD, 16'h88EF};

    bus.dataa = 8'h00; bus.datab = 8'h00;
    bus.input_sel = 2'b00; bus.shift_sel = 2'b00;
    bus.clk_ena = 1'b0; bus.sclr_n = 1'b1; bus.done = 1'b0;
    reset_a = 1'b1;
    tick(); tick();
    check("reset count", 32'(bus.count), 32'd0);
    check("reset product", 32'(bus.product8x8), 32'd0);
    check("reset valid", 32'(bus.result_valid), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);
    reset_a = 1'b0;

    // Accumulator trace observed by overlapping done with each step.
    bus.dataa = 8'h12; bus.datab = 8'h34;
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    check("trace clear count", 32'(bus.count), 32'd0);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    check("trace count1", 32'(bus.count), 32'd1);
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b1);
    check("trace count2", 32'(bus.count), 32'd2);
    check("trace acc1", 32'(bus.product8x8), 32'h0008);
    drive(1'b1, 1'b1, 2'b10, 2'b01, 1'b1);
    check("trace count3", 32'(bus.count), 32'd3);
    check("trace acc2", 32'(bus.product8x8), 32'h0068);
    drive(1'b1, 1'b1, 2'b11, 2'b10, 1'b1);
    check("trace count0", 32'(bus.count), 32'd0);
    check("trace acc3", 32'(bus.product8x8), 32'h00A8);
    drive(1'b0, 1'b1, 2'bxx, 2'bxx, 1'b1);
    check("trace acc4", 32'(bus.product8x8), 32'h03A8);
    drive(1'b0, 1'b1, 2'bxx, 2'bxx, 1'b0);

    for (int i = 0; i < 6; i++)
      run_mult(vecs[i].a, vecs[i].b, 1'b0, vecs[i].prod, $sformatf("vec%0d", i));

    run_mult(8'h12, 8'h34, 1'b1, 16'h03A8, "hold");

    // Misuse: repeated top-nibble step overflows the accumulator.
    bus.dataa = 8'hFF; bus.datab = 8'hFF;
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 2'b10, 1'b0);
    check("misuse no ovf yet", 32'(bus.overflow), 32'd0);
    drive(1'b1, 1'b1, 2'b11, 2'b10, 1'b1);
    check("misuse acc1", 32'(bus.product8x8), 32'hE100);
    check("misuse ovf set", 32'(bus.overflow), 32'd1);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1);
    check("misuse acc2", 32'(bus.product8x8), 32'hC200);
    check("misuse ovf sticky", 32'(bus.overflow), 32'd1);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    check("misuse ovf cleared", 32'(bus.overflow), 32'd0);

    // Gating with X selects, then restart mid-calculation.
    bus.dataa = 8'h12; bus.datab = 8'h34;
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'bxx, 2'bxx, 1'b0);
      check("gate count", 32'(bus.count), 32'd2);
      check("gate product", 32'(bus.product8x8), 32'hC200);
      check("gate overflow", 32'(bus.overflow), 32'd0);
    end
    drive(1'b0, 1'b1, 2'bxx, 2'bxx, 1'b1);
    check("gate acc held", 32'(bus.product8x8), 32'h0068);
    drive(1'b1, 1'b1, 2'b10, 2'b01, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    check("restart count", 32'(bus.count), 32'd0);
    check("restart product kept", 32'(bus.product8x8), 32'h0068);
    drive(1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    check("restart acc zero", 32'(bus.product8x8), 32'h0000);

    // Asynchronous reset mid-accumulate with accumulator at 0x0068.
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b1);
    check("pre-reset product", 32'(bus.product8x8), 32'h0008);
    reset_a = 1'b1;
    #1;
    check("async count", 32'(bus.count), 32'd0);
    check("async product", 32'(bus.product8x8), 32'd0);
    check("async valid", 32'(bus.result_valid), 32'd0);
    check("async overflow", 32'(bus.overflow), 32'd0);
    #2 reset_a = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    check("post-reset acc", 32'(bus.product8x8), 32'h0000);

    // Randomized cycles against the arithmetic model.
    reset_a = 1'b1;
    #1 reset_a = 1'b0;
    m_opa = 0; m_opb = 0; m_acc = 0; m_cnt = 0; m_prod = 0; m_ovf = 0; m_valid = 0;
    for (int n = 0; n < 300; n++) begin
      int isel, ssel, a, b, sum;
      bit ena, clr, dn;
      ena  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      dn   = ($urandom_range(0, 5) == 0);
      isel = $urandom_range(0, 3);
      ssel = $urandom_range(0, 3);
      bus.dataa = 8'($urandom_range(0, 255));
      bus.datab = 8'($urandom_range(0, 255));
      a = HOLD ? m_opa : int'(bus.dataa);
      b = HOLD ? m_opb : int'(bus.datab);
      m_valid = dn;
      if (dn) m_prod = m_acc;
      if (ena) begin
        if (clr) begin
          m_cnt = 0; m_acc = 0; m_ovf = 0;
          if (HOLD) begin
            m_opa = int'(bus.dataa);
            m_opb = int'(bus.datab);
          end
        end else begin
          sum   = m_acc + ref_pp(a, b, isel, ssel);
          m_ovf = STICKY ? (m_ovf || sum > 65535) : (sum > 65535);
          m_acc = sum % 65536;
          m_cnt = (m_cnt + 1) % 4;
        end
      end
      drive(ena, !clr, 2'(isel), 2'(ssel), dn);
      check("rand count", 32'(bus.count), 32'(m_cnt));
      check("rand product", 32'(bus.product8x8), 32'(m_prod));
      check("rand valid", 32'(bus.result_valid), 32'(m_valid));
      check("rand overflow", 32'(bus.overflow), 32'(m_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
